wb_port_arbiter: RTL

Arbiter and output register in front of the Write-Back stage. It shares the single GPR write-back path between two requesters:
- the Memory stage, which delivers a full `mem2wb_t` payload;
- a long-latency execution unit (multi-cycle mul/div), which delivers `rd` plus a result.

The winner is registered into one `mem2wb_t` entry that WB consumes under a valid/ready handshake. An optional aging guard keeps the long-latency unit from starving behind a continuous MEM stream.

---
 rtl/wb_port_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single GPR write-back path between the Memory stage and a
//   long-latency execution unit (mul/div). The winning payload is registered
//   into one mem2wb_t entry that WB drains under a valid/ready handshake.
//   A full entry can be replaced on the same edge it drains, so a steady
//   stream of one payload per cycle is sustained while wb_ready_i is high.
//
//   Optional feature macro: WB_STARVE_GUARD_EN
//     defined   - age counter lets a waiting long-latency request take priority
//                 after losing STARVE_LIMIT cycles; starve_o is live.
//     undefined - MEM has strict priority; starve_o is tied to 0.
//
//   Ports
//     clk, rst                 core clock, synchronous active-high reset
//     mem_valid_i/mem_ready_o  MEM payload handshake, mem_data_i payload
//     ll_valid_i/ll_ready_o    long-latency handshake, ll_rd_i / ll_data_i
//     wb_valid_o/wb_ready_i    output entry handshake, wb_data_o payload
//     starve_o                 aging guard is forcing long-latency priority
// -----------------------------------------------------------------------------

package core_pkg;
   localparam int DATA_WIDTH    = 32;
   localparam int RF_ADDR_WIDTH = 5;

   // GPR write-enable encoding: 00 no write, 01 write exe_out, 10 write load data
   localparam logic [1:0] GPR_WE_EXE = 2'b01;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]    exe_out;
      logic [DATA_WIDTH-1:0]    op3;
      logic [RF_ADDR_WIDTH-1:0] rd;
      logic [1:0]               gpr_ctrl;
      logic [2:0]               csr_ctrl;
      logic [3:0]               mem_ctrl;
   } mem2wb_t;
endpackage

module wb_port_arbiter
   import core_pkg::*;
#(
   parameter int         STARVE_LIMIT = 4,
   parameter logic [1:0] LL_GPR_CTRL  = core_pkg::GPR_WE_EXE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_valid_i,
   output logic                     mem_ready_o,
   input  mem2wb_t                  mem_data_i,
   input  logic                     ll_valid_i,
   output logic                     ll_ready_o,
   input  logic [RF_ADDR_WIDTH-1:0] ll_rd_i,
   input  logic [DATA_WIDTH-1:0]    ll_data_i,
   output logic                     wb_valid_o,
   input  logic                     wb_ready_i,
   output mem2wb_t                  wb_data_o,
   output logic                     starve_o
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("wb_port_arbiter: STARVE_LIMIT out of range 1..15");
   end

   logic    wb_valid_q;
   mem2wb_t wb_data_q;
   logic    load_en;
   logic    grant_mem;
   logic    grant_ll;
   logic    aged;        // long-latency request has waited STARVE_LIMIT cycles
   mem2wb_t ll_pkt;

   // Entry can accept whenever it is empty or being drained this cycle.
   // Held low during reset so nothing is accepted and then discarded.
   assign load_en = !rst & (!wb_valid_q | wb_ready_i);

   always_comb begin
      grant_mem = mem_valid_i & !(ll_valid_i & aged);
      grant_ll  = ll_valid_i  & (!mem_valid_i | aged);
   end

   assign mem_ready_o = load_en & grant_mem;
   assign ll_ready_o  = load_en & grant_ll;

   always_comb begin
      ll_pkt          = '0;
      ll_pkt.exe_out  = ll_data_i;
      ll_pkt.rd       = ll_rd_i;
      ll_pkt.gpr_ctrl = LL_GPR_CTRL;
   end

`ifdef WB_STARVE_GUARD_EN
   localparam int AW = $clog2(STARVE_LIMIT + 1);
   logic [AW-1:0] age_q;

   assign aged = (age_q == AW'(STARVE_LIMIT));

   // Counts cycles a valid long-latency request has gone unserved,
   // including cycles stalled by WB back-pressure.
   always_ff @(posedge clk) begin
      if (rst)                           age_q <= '0;
      else if (ll_ready_o | !ll_valid_i) age_q <= '0;
      else if (!aged)                    age_q <= age_q + 1'b1;
   end

   assign starve_o = aged & ll_valid_i;
`else
   assign aged     = 1'b0;
   assign starve_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
      end else if (load_en) begin
         wb_valid_q <= grant_mem | grant_ll;
         if (grant_mem)     wb_data_q <= mem_data_i;
         else if (grant_ll) wb_data_q <= ll_pkt;
      end
   end

   assign wb_valid_o = wb_valid_q;
   assign wb_data_o  = wb_data_q;

endmodule
